// File: rtl/gen_channel_scanner_if.sv
// Beat stream carrying (index, value) pairs from the channel scanner to its consumer.
// Latency: none, this is a bundle of wires only.
// Backpressure: the consumer holds out_ready low to stall; the producer keeps the beat stable.
//
// Signals:
//   out_valid  producer -> consumer  beat valid
//   out_ready  consumer -> producer  consumer can accept the beat this cycle
//   out_index  producer -> consumer  channel index of the beat
//   out_value  producer -> consumer  channel value snapshot of the beat
interface gen_channel_scanner_if #(
    parameter int IDXW  = 3,
    parameter int WIDTH = 8
);
    logic             out_valid;
    logic             out_ready;
    logic [IDXW-1:0]  out_index;
    logic [WIDTH-1:0] out_value;

    modport master (
        output out_valid,
        output out_index,
        output out_value,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_index,
        input  out_value,
        output out_ready
    );
endinterface

// File: rtl/gen_channel_scanner.sv
// Bank of NCHAN generate-scoped counters plus a scanner that streams (index, value) beats.
// Latency: first beat is visible one cycle after start; one beat per cycle when unstalled.
// Backpressure: out_ready low freezes the presented beat (snapshot); later beats slip by one cycle.
//
// Ports:
//   clock, reset_n   rising-edge clock, asynchronous active-low reset
//   inc[NCHAN]       per-channel increment strobes (counters wrap modulo 2^WIDTH)
//   start, reverse   scan request (honoured only when idle) and its direction
//   out              beat stream (master side): out_valid/out_ready/out_index/out_value
//   busy, done       scan in progress; one-cycle pulse after the final beat is accepted
module gen_channel_scanner #(
    parameter int  NCHAN = 5,
    parameter int  WIDTH = 8,
    parameter int  STEP  = 1,
    localparam int IDXW  = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [NCHAN-1:0]      inc,
    input  logic                  start,
    input  logic                  reverse,
    gen_channel_scanner_if.master out,
    output logic                  busy,
    output logic                  done
);

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHAN - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DONE
    } state_t;

    // Counter values gathered out of the generate scopes so the scanner can
    // read them by a run-time index.
    logic [WIDTH-1:0] ch_val [NCHAN];

    for (genvar i = 0; i < NCHAN; i++) begin : CH
        // Truncation to WIDTH bits gives the modulo-2^WIDTH reset value.
        localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(i * STEP);

        logic [WIDTH-1:0] cnt;

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                cnt <= RST_VAL;
            end else if (inc[i]) begin
                cnt <= cnt + WIDTH'(1);
            end
        end

        assign ch_val[i] = cnt;
    end

    state_t           state, state_nxt;
    logic             dir, dir_nxt;
    logic             vld_nxt;
    logic [IDXW-1:0]  idx_nxt;
    logic [WIDTH-1:0] val_nxt;
    logic             busy_nxt;
    logic             done_nxt;
    logic             load;
    logic [IDXW-1:0]  load_idx;
    logic             is_last;

    // The final beat depends on the direction latched at start, not the live input.
    assign is_last = dir ? (out.out_index == '0) : (out.out_index == LAST_IDX);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            dir           <= 1'b0;
            out.out_valid <= 1'b0;
            out.out_index <= '0;
            out.out_value <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            state         <= state_nxt;
            dir           <= dir_nxt;
            out.out_valid <= vld_nxt;
            out.out_index <= idx_nxt;
            out.out_value <= val_nxt;
            busy          <= busy_nxt;
            done          <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        dir_nxt   = dir;
        vld_nxt   = out.out_valid;
        idx_nxt   = out.out_index;
        val_nxt   = out.out_value;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        load      = 1'b0;
        load_idx  = out.out_index;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    dir_nxt   = reverse;
                    load      = 1'b1;
                    load_idx  = reverse ? LAST_IDX : '0;
                    vld_nxt   = 1'b1;
                    busy_nxt  = 1'b1;
                    state_nxt = ST_SCAN;
                end
            end
            ST_SCAN: begin
                // out_valid is always high here, so out_ready alone marks a handshake.
                if (out.out_ready) begin
                    if (is_last) begin
                        vld_nxt   = 1'b0;
                        done_nxt  = 1'b1;
                        state_nxt = ST_DONE;
                    end else begin
                        load     = 1'b1;
                        load_idx = dir ? (out.out_index - IDXW'(1))
                                       : (out.out_index + IDXW'(1));
                    end
                end
            end
            ST_DONE: begin
                busy_nxt  = 1'b0;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // Snapshot takes the register value before this edge, so a coincident
        // inc on the same channel is not reflected in the beat.
        if (load) begin
            idx_nxt = load_idx;
            val_nxt = ch_val[load_idx];
        end
    end

endmodule
